// File: rtl/scatter_accumulator.sv
// Bilinear charge-scatter engine: for each particle, read the four neighbouring
// grid cells (corner k on bank k, k = {dy, dx}), add bilinear weights and write
// the sums back. Forwarding covers the read-to-write window of the RAM.
// Optional feature macro: ACC_SAT_EN (clamp sums at 2^CWIDTH-1 instead of wrapping).
module scatter_accumulator #(
  parameter int PWIDTH = 16,
  parameter int PFRAC  = 4,
  parameter int XBITS  = 6,
  parameter int YBITS  = 6,
  parameter int CWIDTH = 18,
  parameter int QSHIFT = 2,
  parameter int RD_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic [PWIDTH-1:0]          gyro_y,
  input  logic [PWIDTH-1:0]          gyro_x,
  output logic                       rd_en_out,
  output logic [4*(YBITS+XBITS)-1:0] raddr_out,
  input  logic [4*CWIDTH-1:0]        rdata_in,
  output logic                       wr_en_out,
  output logic [4*(YBITS+XBITS)-1:0] waddr_out,
  output logic [4*CWIDTH-1:0]        wdata_out,
  output logic                       idle_out
);

  localparam int AW = YBITS + XBITS;
  localparam int H  = RD_LAT + 1;   // writes not yet visible to a read issued RD_LAT cycles ago
  localparam int WW = PFRAC + 1;    // weight width, holds 2^PFRAC
  localparam int PW = 2 * WW;       // weight product width

  // Coordinate split: fraction, and integer part truncated to the grid size
  logic [PFRAC-1:0] frac_x, frac_y;
  logic [XBITS-1:0] int_x;
  logic [YBITS-1:0] int_y;
  logic [WW-1:0]    wx [2];
  logic [WW-1:0]    wy [2];
  logic             unused_bits;

  assign frac_x = gyro_x[PFRAC-1:0];
  assign frac_y = gyro_y[PFRAC-1:0];
  assign int_x  = gyro_x[PFRAC +: XBITS];
  assign int_y  = gyro_y[PFRAC +: YBITS];
  assign unused_bits = ^{gyro_x[PWIDTH-1:PFRAC+XBITS], gyro_y[PWIDTH-1:PFRAC+YBITS]};

  assign wx[1] = {1'b0, frac_x};
  assign wx[0] = WW'(2**PFRAC) - {1'b0, frac_x};
  assign wy[1] = {1'b0, frac_y};
  assign wy[0] = WW'(2**PFRAC) - {1'b0, frac_y};

  // Per-corner address and contribution for the incoming particle
  logic [4*AW-1:0]     addr_new;
  logic [4*CWIDTH-1:0] ctb_new;

  // Pipeline: index 0 is the read-issue stage, index RD_LAT is the add stage
  logic [RD_LAT:0]     v_pipe;
  logic [4*AW-1:0]     addr_pipe [RD_LAT+1];
  logic [4*CWIDTH-1:0] ctb_pipe  [RD_LAT+1];

  // History of add-stage results; entry 0 is the youngest and drives the write port
  logic [H-1:0]        hist_v;
  logic [4*AW-1:0]     hist_addr [H];
  logic [4*CWIDTH-1:0] hist_val  [H];

  logic [4*CWIDTH-1:0] sum_flat;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_corner
      localparam int DX = gi % 2;
      localparam int DY = gi / 2;

      logic [XBITS-1:0]  cx;
      logic [YBITS-1:0]  cy;
      logic [PW-1:0]     prod;
      logic [AW-1:0]     add_addr;
      logic [CWIDTH-1:0] add_ctb;
      logic [CWIDTH-1:0] base;
      logic [CWIDTH:0]   sum_ext;

      // Periodic wrap falls out of the modulo-2^n add
      assign cx   = int_x + XBITS'(DX);
      assign cy   = int_y + YBITS'(DY);
      assign prod = PW'(wy[DY]) * PW'(wx[DX]);
      assign addr_new[gi*AW +: AW]         = {cy, cx};
      assign ctb_new[gi*CWIDTH +: CWIDTH]  = CWIDTH'(prod >> QSHIFT);

      assign add_addr = addr_pipe[RD_LAT][gi*AW +: AW];
      assign add_ctb  = ctb_pipe[RD_LAT][gi*CWIDTH +: CWIDTH];

      // Base value: youngest matching in-flight result on this bank, else RAM data
      always_comb begin
        base = rdata_in[gi*CWIDTH +: CWIDTH];
        for (int h = H - 1; h >= 0; h--) begin
          if (hist_v[h] && (hist_addr[h][gi*AW +: AW] == add_addr)) begin
            base = hist_val[h][gi*CWIDTH +: CWIDTH];
          end
        end
      end

      assign sum_ext = {1'b0, base} + {1'b0, add_ctb};
`ifdef ACC_SAT_EN
      assign sum_flat[gi*CWIDTH +: CWIDTH] = sum_ext[CWIDTH] ? {CWIDTH{1'b1}} : sum_ext[CWIDTH-1:0];
`else
      assign sum_flat[gi*CWIDTH +: CWIDTH] = sum_ext[CWIDTH-1:0];
`endif
    end
  endgenerate

  // Particle pipeline from read issue to the add stage
  always_ff @(posedge clk) begin
    if (rst) begin
      v_pipe <= '0;
      for (int s = 0; s <= RD_LAT; s++) begin
        addr_pipe[s] <= '0;
        ctb_pipe[s]  <= '0;
      end
    end else begin
      v_pipe <= {v_pipe[RD_LAT-1:0], valid_in};
      if (valid_in) begin
        addr_pipe[0] <= addr_new;
        ctb_pipe[0]  <= ctb_new;
      end
      for (int s = 1; s <= RD_LAT; s++) begin
        addr_pipe[s] <= addr_pipe[s-1];
        ctb_pipe[s]  <= ctb_pipe[s-1];
      end
    end
  end

  // Forwarding history; entry 0 doubles as the registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_v <= '0;
      for (int h = 0; h < H; h++) begin
        hist_addr[h] <= '0;
        hist_val[h]  <= '0;
      end
    end else begin
      hist_v <= {hist_v[H-2:0], v_pipe[RD_LAT]};
      if (v_pipe[RD_LAT]) begin
        hist_addr[0] <= addr_pipe[RD_LAT];
        hist_val[0]  <= sum_flat;
      end
      for (int h = 1; h < H; h++) begin
        hist_addr[h] <= hist_addr[h-1];
        hist_val[h]  <= hist_val[h-1];
      end
    end
  end

  assign rd_en_out = v_pipe[0];
  assign raddr_out = addr_pipe[0];
  assign wr_en_out = hist_v[0];
  assign waddr_out = hist_addr[0];
  assign wdata_out = hist_val[0];
  assign idle_out  = ~((|v_pipe) | hist_v[0]);

endmodule

// File: tb/tb_scatter_accumulator.sv
// Directed bench for scatter_accumulator with a 4-bank RAM model (read latency 2,
// old data on read/write collision). Expected values are hand-computed.
module tb_scatter_accumulator;

  localparam int AW = 12;
  localparam int CW = 18;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            valid_in = 1'b0;
  logic [15:0]     gyro_y = '0;
  logic [15:0]     gyro_x = '0;
  logic            rd_en_out;
  logic [4*AW-1:0] raddr_out;
  logic [4*CW-1:0] rdata_in;
  logic            wr_en_out;
  logic [4*AW-1:0] waddr_out;
  logic [4*CW-1:0] wdata_out;
  logic            idle_out;

  logic            fill_en = 1'b0;
  logic [CW-1:0]   fill_val = '0;
  logic [CW-1:0]   mem [4][4096];
  logic [4*CW-1:0] rd_q1;

  int n_checks = 0;
  int n_pass   = 0;

  scatter_accumulator #(
    .PWIDTH(16), .PFRAC(4), .XBITS(6), .YBITS(6),
    .CWIDTH(18), .QSHIFT(0), .RD_LAT(2)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .gyro_y(gyro_y), .gyro_x(gyro_x),
    .rd_en_out(rd_en_out), .raddr_out(raddr_out), .rdata_in(rdata_in),
    .wr_en_out(wr_en_out), .waddr_out(waddr_out), .wdata_out(wdata_out),
    .idle_out(idle_out)
  );

  always #5 clk = ~clk;

  // RAM banks: two-cycle read, writes land after the same-edge read
  always @(posedge clk) begin
    if (fill_en) begin
      for (int k = 0; k < 4; k++)
        for (int i = 0; i < 4096; i++)
          mem[k][i] <= fill_val;
    end else if (wr_en_out) begin
      for (int k = 0; k < 4; k++)
        mem[k][waddr_out[k*AW +: AW]] <= wdata_out[k*CW +: CW];
    end
    if (rd_en_out) begin
      for (int k = 0; k < 4; k++)
        rd_q1[k*CW +: CW] <= mem[k][raddr_out[k*AW +: AW]];
    end
    rdata_in <= rd_q1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else begin
      n_pass++;
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic fill(input logic [CW-1:0] v);
    fill_val = v;
    fill_en  = 1'b1;
    tick();
    fill_en  = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 8; i++) tick();
  endtask

  function automatic logic [31:0] wd(input int k);
    return 32'(wdata_out[k*CW +: CW]);
  endfunction

  function automatic logic [31:0] wa(input int k);
    return 32'(waddr_out[k*AW +: AW]);
  endfunction

  function automatic logic [31:0] ra(input int k);
    return 32'(raddr_out[k*AW +: AW]);
  endfunction

  logic wr_seen;

  initial begin
    rdata_in = '0;
    rd_q1    = '0;
    tick(); tick(); tick();
    check("reset rd_en", 32'(rd_en_out), 0);
    check("reset wr_en", 32'(wr_en_out), 0);
    check("reset idle", 32'(idle_out), 1);
    check("reset raddr0", ra(0), 0);
    check("reset wdata0", wd(0), 0);
    rst = 1'b0;
    tick();

    // Single particle: y = 2 + 8/16, x = 3 + 4/16, RAM holds 10
    fill(18'd10);
    gyro_y = 16'd40; gyro_x = 16'd52; valid_in = 1'b1;
    tick(); valid_in = 1'b0;                    // cycle 1
    check("single rd_en", 32'(rd_en_out), 1);
    check("single raddr0", ra(0), 131);
    check("single raddr3", ra(3), 196);
    check("single idle busy", 32'(idle_out), 0);
    tick(); tick(); tick();                     // cycle 4
    check("single wr_en", 32'(wr_en_out), 1);
    check("single waddr1", wa(1), 132);
    check("single waddr2", wa(2), 195);
    check("single wdata0", wd(0), 106);
    check("single wdata1", wd(1), 42);
    check("single wdata2", wd(2), 106);
    check("single wdata3", wd(3), 42);
    tick();                                     // cycle 5
    check("single wr_en drop", 32'(wr_en_out), 0);
    check("single idle back", 32'(idle_out), 1);
    settle();

    // Back-to-back x3, RAM zero
    fill(18'd0);
    valid_in = 1'b1;
    tick(); tick(); tick(); valid_in = 1'b0;    // cycle 3
    tick(); check("b2b wdata0 #1", wd(0), 96);
    tick(); check("b2b wdata0 #2", wd(0), 192);
    check("b2b idle busy", 32'(idle_out), 0);
    tick(); check("b2b wdata0 #3", wd(0), 288);
    check("b2b wdata1 #3", wd(1), 96);
    check("b2b wr_en #3", 32'(wr_en_out), 1);
    settle();

    // Periodic wrap at x_int = y_int = 63 (with a stray high integer bit)
    gyro_y = 16'd1016; gyro_x = 16'd1016 | 16'h4000; valid_in = 1'b1;
    tick(); valid_in = 1'b0;
    check("wrap raddr3", ra(3), 0);
    check("wrap raddr1", ra(1), 4032);
    check("wrap raddr0", ra(0), 4095);
    settle();

    // Overflow: base 2^18-11 plus contributions 96 / 32
    fill(18'd262133);
    gyro_y = 16'd40; gyro_x = 16'd52; valid_in = 1'b1;
    tick(); valid_in = 1'b0;
    tick(); tick(); tick();
`ifdef ACC_SAT_EN
    check("ovf wdata0", wd(0), 262143);
    check("ovf wdata1", wd(1), 262143);
`else
    check("ovf wdata0", wd(0), 85);
    check("ovf wdata1", wd(1), 21);
`endif
    settle();

    // Gap of 3: second particle forwarded from the oldest history entry
    fill(18'd0);
    valid_in = 1'b1;
    tick(); valid_in = 1'b0;                    // cycle 1
    tick(); tick(); valid_in = 1'b1;            // cycle 3
    tick(); valid_in = 1'b0;                    // cycle 4
    check("gap3 wdata0 #1", wd(0), 96);
    tick(); tick(); tick();                     // cycle 7
    check("gap3 wr_en #2", 32'(wr_en_out), 1);
    check("gap3 wdata0 #2", wd(0), 192);
    check("gap3 wdata3 #2", wd(3), 64);
    settle();

    // Gap of 4: second particle reads the written value from RAM
    fill(18'd0);
    valid_in = 1'b1;
    tick(); valid_in = 1'b0;                    // cycle 1
    tick(); tick(); tick(); valid_in = 1'b1;    // cycle 4
    check("gap4 wdata0 #1", wd(0), 96);
    tick(); valid_in = 1'b0;                    // cycle 5
    tick(); tick(); tick();                     // cycle 8
    check("gap4 wdata0 #2", wd(0), 192);
    check("gap4 wdata1 #2", wd(1), 64);
    settle();

    // Reset mid-flight drops the particle
    valid_in = 1'b1;
    tick(); valid_in = 1'b0;                    // cycle 1
    tick(); rst = 1'b1;                         // cycle 2
    tick();                                     // cycle 3
    check("rst idle", 32'(idle_out), 1);
    check("rst rd_en", 32'(rd_en_out), 0);
    rst = 1'b0;
    wr_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (wr_en_out) wr_seen = 1'b1;
    end
    check("rst no write", 32'(wr_seen), 0);
    check("rst idle after", 32'(idle_out), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
